// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
//   DATA_BITS            : data bits per frame
//   DEFAULT_CLKS_PER_BIT : default clock cycles per bit (12 MHz / 115200)
//   uart_state_e         : 3-bit state encoding shared by TX and RX FSMs
package uart_pkg;

  localparam int          DATA_BITS            = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    s_IDLE    = 3'd0,
    s_START   = 3'd1,
    s_DATA    = 3'd2,
    s_PARITY  = 3'd3,
    s_STOP    = 3'd4,
    s_CLEANUP = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 (the idle level of the line), so reset never looks
// like a start bit.
//   i_Clock : system clock
//   i_Reset : asynchronous active-high reset
//   i_d     : asynchronous input
//   o_q     : synchronized output (2 cycles of latency)
module uart_rx_sync (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_sync_fsm.sv
// UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit.
// The line is synchronized, start bits are qualified at mid-bit, and every
// data/stop bit is sampled one bit period later (i.e. at its own mid-bit).
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : an even-parity bit follows the data bits
//   undefined : no parity bit; o_Parity_Err is constant 0
//
// Ports:
//   i_Clock      : system clock, rising edge
//   i_Reset      : asynchronous active-high reset
//   i_Rx_Serial  : asynchronous serial input, idle high
//   o_Rx_DV      : one-cycle strobe, o_Rx_Byte holds a new good byte
//   o_Rx_Byte    : last good byte, held until the next good byte
//   o_Rx_Active  : high from start-bit detect through CLEANUP
//   o_Frame_Err  : one-cycle strobe, stop bit sampled low
//   o_Parity_Err : one-cycle strobe, parity mismatch
//
// state     | meaning
// ----------+-------------------------------------------------
// s_IDLE    | waiting for the line to go low
// s_START   | counting to mid start bit, reject glitches
// s_DATA    | sampling 8 data bits at mid-bit
// s_PARITY  | sampling the parity bit (parity builds only)
// s_STOP    | sampling the stop bit, issuing the result strobe
// s_CLEANUP | one cycle, strobes drop, then back to IDLE
module uart_rx_sync_fsm
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Frame_Err,
  output logic       o_Parity_Err
);

  localparam logic [31:0] HALF     = 32'((CLKS_PER_BIT - 1) / 2);
  localparam logic [31:0] LAST     = 32'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_d     (i_Rx_Serial),
    .o_q     (rx_s)
  );

  uart_state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        fe_q, fe_d;
  logic        active_q, active_d;
`ifdef UART_RX_PARITY_EN
  logic        pe_q, pe_d;
  logic        par_bad_q, par_bad_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 32'd1;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    fe_d     = 1'b0;
    active_d = active_q;
`ifdef UART_RX_PARITY_EN
    pe_d      = 1'b0;
    par_bad_d = par_bad_q;
`endif

    case (state_q)
      s_IDLE: begin
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
        if (!rx_s) begin
          state_d  = s_START;
          active_d = 1'b1;
        end
      end

      s_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = s_DATA;
          end else begin
            state_d  = s_IDLE;
            active_d = 1'b0;
          end
        end
      end

      s_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = s_PARITY;
`else
            state_d = s_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      s_PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d     = '0;
          // even parity: data bits plus parity bit must XOR to 0
          par_bad_d = (^shift_q) ^ rx_s;
          state_d   = s_STOP;
        end
      end
`endif

      s_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = s_CLEANUP;
          // framing error wins over parity error
          if (!rx_s) begin
            fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            pe_d = 1'b1;
`endif
          end else begin
            dv_d   = 1'b1;
            byte_d = shift_q;
          end
        end
      end

      s_CLEANUP: begin
        cnt_d    = '0;
        state_d  = s_IDLE;
        active_d = 1'b0;
      end

      default: begin
        cnt_d    = '0;
        idx_d    = '0;
        state_d  = s_IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= s_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      fe_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      fe_q     <= fe_d;
      active_q <= active_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      pe_q      <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      pe_q      <= pe_d;
      par_bad_q <= par_bad_d;
    end
  end

  assign o_Parity_Err = pe_q;
`else
  assign o_Parity_Err = 1'b0;
`endif

  assign o_Rx_DV     = dv_q;
  assign o_Rx_Byte   = byte_q;
  assign o_Rx_Active = active_q;
  assign o_Frame_Err = fe_q;

endmodule

// File: tb/tb_uart_rx_sync_fsm.sv
module tb_uart_rx_sync_fsm;

  localparam int CPB  = 8;
  localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  // line-fall to result-strobe delay, tolerance +-1 for synchronizer phase
  localparam int LAT = 2 + (HALF + 1) + 9 * CPB + (PAR ? CPB : 0);

  localparam int K_DV = 0;
  localparam int K_FE = 1;
  localparam int K_PE = 2;

  typedef struct {
    int         kind;
    logic [7:0] b;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line = 1'b1;
  logic       dv, act, fe, pe;
  logic [7:0] rbyte;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic [7:0] model_byte = 8'h00;

  uart_rx_sync_fsm #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Rx_Serial  (line),
    .o_Rx_DV      (dv),
    .o_Rx_Byte    (rbyte),
    .o_Rx_Active  (act),
    .o_Frame_Err  (fe),
    .o_Parity_Err (pe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drive one whole frame and push the expected outcome.
  task automatic send(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    exp_t e;
    logic p;
    @(negedge clk);
    if (!stop_ok)               e.kind = K_FE;
    else if (PAR && !par_ok)    e.kind = K_PE;
    else begin
      e.kind     = K_DV;
      model_byte = d;
    end
    e.b   = model_byte;
    e.due = cyc + LAT;
    q.push_back(e);
    line = 1'b0;
    idle(CPB);
    check("active_mid_frame", {31'b0, act}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      idle(CPB);
    end
    if (PAR) begin
      p    = (^d) ^ !par_ok;
      line = p;
      idle(CPB);
    end
    line = stop_ok;
    idle(CPB);
    line = 1'b1;
  endtask

  task automatic glitch(input int n);
    @(negedge clk);
    line = 1'b0;
    idle(n);
    line = 1'b1;
    idle(2 * CPB);
    check("active_after_glitch", {31'b0, act}, 32'd0);
  endtask

  task automatic check_all_zero(input string nm);
    check(nm, {24'b0, rbyte} | {28'b0, dv, act, fe, pe}, 32'd0);
  endtask

  // monitor: pop and compare on every strobe
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (dv || fe || pe)) begin
      check("strobe_onehot", 32'(dv) + 32'(fe) + 32'(pe), 32'd1);
      if (q.size() == 0) begin
        check("unexpected_strobe", {29'b0, dv, fe, pe}, 32'd0);
      end else begin
        e = q.pop_front();
        check("strobe_kind", fe ? K_FE : (pe ? K_PE : K_DV), e.kind);
        check("rx_byte", {24'b0, rbyte}, {24'b0, e.b});
        checks++;
        if (cyc < e.due - 1 || cyc > e.due + 1) begin
          errors++;
          $display("FAIL latency: strobe at cycle %0d expected %0d +-1", cyc, e.due);
        end
      end
    end
  end

  initial begin
    bit   sok, pok;
    int   r;
    logic [7:0] d;

    idle(3);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    idle(4);
    check_all_zero("post_reset_idle");

    // 1: 0x55 good
    send(8'h55, 1'b1, 1'b1);
    idle(3 * CPB);
    check("active_after_cleanup", {31'b0, act}, 32'd0);

    // 2: glitch, then 0xA5
    glitch(2);
    send(8'hA5, 1'b1, 1'b1);
    idle(2 * CPB);

    // 3: framing error keeps previous byte
    send(8'hA3, 1'b0, 1'b1);
    idle(2 * CPB);
    check("byte_held_after_fe", {24'b0, rbyte}, 32'hA5);

    // 4: back-to-back
    send(8'h00, 1'b1, 1'b1);
    send(8'hFF, 1'b1, 1'b1);
    idle(2 * CPB);

    // 5: reset during data bit 4 of 0x3C
    d = 8'h3C;
    @(negedge clk);
    line = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      line = d[i];
      idle(CPB);
    end
    line = d[4];
    idle(CPB / 2);
    rst = 1'b1;
    idle(2);
    check_all_zero("outputs_in_reset");
    line = 1'b1;
    idle(3);
    check_all_zero("outputs_in_reset_late");
    model_byte = 8'h00;
    rst = 1'b0;
    idle(2 * CPB);
    check_all_zero("after_midframe_reset");
    send(8'h81, 1'b1, 1'b1);
    idle(2 * CPB);

    // 6: parity
    if (PAR) begin
      send(8'h07, 1'b1, 1'b1);
      idle(CPB);
      send(8'h07, 1'b1, 1'b0);
      idle(2 * CPB);
      check("byte_held_after_pe", {24'b0, rbyte}, 32'h07);
    end

    // random traffic
    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        glitch(int'($urandom_range(1, 2)));
      end else begin
        d   = 8'($urandom);
        sok = (r != 1);
        pok = (r != 2);
        send(d, sok, pok);
        // after a low stop bit, give the line a full bit high before the next start
        idle(sok ? int'($urandom_range(0, 3)) : CPB + int'($urandom_range(0, 3)));
      end
    end

    idle(LAT + 4 * CPB);
    check("scoreboard_drained", q.size(), 32'd0);
    check("byte_final", {24'b0, rbyte}, {24'b0, model_byte});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
